// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_port_arbiter_if                                               |
// | Bundle of pipeline writeback, md-unit result and regfile write   |
// | port signals shared by the writeback-port arbiter.               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface wb_port_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             md_req;
  logic [4:0]       md_rd;
  logic [31:0]      md_data;
  logic             md_ack;
  logic             stall;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic [31:0]      rf_data;
  logic [CNT_W-1:0] stall_cnt;

  // Requester side: pipeline writeback and md unit drive requests,
  // observe the handshake and the registered write port.
  modport master (
    output wb_valid, wb_rd, wb_data, md_req, md_rd, md_data,
    input  md_ack, stall, rf_we, rf_addr, rf_data, stall_cnt
  );

  // Arbiter side.
  modport slave (
    input  wb_valid, wb_rd, wb_data, md_req, md_rd, md_data,
    output md_ack, stall, rf_we, rf_addr, rf_data, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_port_arbiter                                                  |
// | Shares the single regfile write port between the pipeline        |
// | writeback stage (priority) and the multiply/divide unit. An md   |
// | result denied MAX_WAIT times is forced through by stalling the   |
// | pipeline for one cycle. Keeps a saturating stall-cycle counter.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0]       MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state;
  logic [3:0]       wait_cnt;
  logic             rf_we_q;
  logic [4:0]       rf_addr_q;
  logic [31:0]      rf_data_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic wb_eff;
  logic md_eff;
  logic md_zero;
  logic starved;
  logic grant_md;
  logic stall_now;

  // Request qualification and grant decision; r0 writes are dropped,
  // and a starved md request overrides pipeline priority.
  always_comb begin
    wb_eff    = bus.wb_valid && (bus.wb_rd != 5'd0);
    md_eff    = bus.md_req && (bus.md_rd != 5'd0);
    md_zero   = bus.md_req && (bus.md_rd == 5'd0);
    starved   = (state == S_WAIT) && (wait_cnt == MAX_WAIT_C);
    grant_md  = md_eff && (!wb_eff || starved);
    stall_now = grant_md && wb_eff && !reset;
  end

  assign bus.md_ack    = (grant_md || md_zero) && !reset;
  assign bus.stall     = stall_now;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.stall_cnt = stall_cnt_q;

  // Denial tracking: count consecutive denials of a live md request;
  // a grant or a dropped request clears the history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else if (grant_md || !md_eff) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= S_WAIT;
      wait_cnt <= (state == S_IDLE) ? 4'd1 : wait_cnt + 4'd1;
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= 32'd0;
    end else if (grant_md) begin
      rf_we_q   <= 1'b1;
      rf_addr_q <= bus.md_rd;
      rf_data_q <= bus.md_data;
    end else if (wb_eff) begin
      rf_we_q   <= 1'b1;
      rf_addr_q <= bus.wb_rd;
      rf_data_q <= bus.wb_data;
    end else begin
      rf_we_q   <= 1'b0;
    end
  end

  // Saturating count of pipeline stall cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_now && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_port_arbiter                                               |
// | Directed vector bench for wb_port_arbiter; a second instance     |
// | with a 4-bit stall counter shares the stimulus.                  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        md_req = 1'b0;
  logic [4:0]  md_rd = 5'd0;
  logic [31:0] md_data = 32'd0;

  int tests  = 0;
  int failed = 0;
  int cnt_exp = 0;

  wb_port_arbiter_if #(.CNT_W(16)) bus ();
  wb_port_arbiter_if #(.CNT_W(4))  bus_s ();

  assign bus.wb_valid   = wb_valid;
  assign bus.wb_rd      = wb_rd;
  assign bus.wb_data    = wb_data;
  assign bus.md_req     = md_req;
  assign bus.md_rd      = md_rd;
  assign bus.md_data    = md_data;
  assign bus_s.wb_valid = wb_valid;
  assign bus_s.wb_rd    = wb_rd;
  assign bus_s.wb_data  = wb_data;
  assign bus_s.md_req   = md_req;
  assign bus_s.md_rd    = md_rd;
  assign bus_s.md_data  = md_data;

  wb_port_arbiter #(.MAX_WAIT(4), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  wb_port_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wbv;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        mdq;
    logic [4:0]  mdr;
    logic [31:0] mdd;
    logic        ack;
    logic        stl;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic wbv, logic [4:0] wbr, logic [31:0] wbd,
                              logic mdq, logic [4:0] mdr, logic [31:0] mdd,
                              logic ack, logic stl, logic we,
                              logic [4:0] addr, logic [31:0] data);
    vec_t v;
    v.wbv = wbv; v.wbr = wbr; v.wbd = wbd;
    v.mdq = mdq; v.mdr = mdr; v.mdd = mdd;
    v.ack = ack; v.stl = stl; v.we = we; v.addr = addr; v.data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    int sat;
    sat = (cnt_exp > 15) ? 15 : cnt_exp;
    chk({tag, " stall_cnt"},   32'(bus.stall_cnt),   32'(cnt_exp));
    chk({tag, " stall_cnt4"},  32'(bus_s.stall_cnt), 32'(sat));
  endtask

  // One clock: drive at negedge, check handshake before the edge,
  // check the registered port just after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    wb_valid = v.wbv; wb_rd = v.wbr; wb_data = v.wbd;
    md_req = v.mdq; md_rd = v.mdr; md_data = v.mdd;
    #1;
    chk({tag, " md_ack"}, 32'(bus.md_ack), 32'(v.ack));
    chk({tag, " stall"},  32'(bus.stall),  32'(v.stl));
    @(posedge clock);
    #1;
    if (v.stl) cnt_exp++;
    chk({tag, " rf_we"},   32'(bus.rf_we),   32'(v.we));
    chk({tag, " rf_addr"}, 32'(bus.rf_addr), 32'(v.addr));
    chk({tag, " rf_data"}, bus.rf_data,      v.data);
    chk_cnt(tag);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " md_ack"},  32'(bus.md_ack),  32'd0);
    chk({tag, " stall"},   32'(bus.stall),   32'd0);
    chk({tag, " rf_we"},   32'(bus.rf_we),   32'd0);
    chk({tag, " rf_addr"}, 32'(bus.rf_addr), 32'd0);
    chk({tag, " rf_data"}, bus.rf_data,      32'd0);
    cnt_exp = 0;
    chk_cnt(tag);
  endtask

  initial begin
    // Table: pipeline-only, starvation, idle md, r0 filtering,
    // illegal drop, same-rd conflict.
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0, 1, 5, 32'hDEADBEEF);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 5, 32'hDEADBEEF);
    vecs[2]  = mk(1, 3, 32'h33,       1, 7, 32'h1234,    0, 0, 1, 3, 32'h33);
    vecs[3]  = mk(1, 3, 32'h33,       1, 7, 32'h1234,    0, 0, 1, 3, 32'h33);
    vecs[4]  = mk(1, 3, 32'h33,       1, 7, 32'h1234,    0, 0, 1, 3, 32'h33);
    vecs[5]  = mk(1, 3, 32'h33,       1, 7, 32'h1234,    0, 0, 1, 3, 32'h33);
    vecs[6]  = mk(1, 3, 32'h33,       1, 7, 32'h1234,    1, 1, 1, 7, 32'h1234);
    vecs[7]  = mk(1, 3, 32'h33,       0, 0, 0,           0, 0, 1, 3, 32'h33);
    vecs[8]  = mk(0, 0, 0,            1, 9, 32'h99,      1, 0, 1, 9, 32'h99);
    vecs[9]  = mk(1, 0, 32'h55,       1, 4, 32'h44,      1, 0, 1, 4, 32'h44);
    vecs[10] = mk(0, 0, 0,            1, 0, 32'h77,      1, 0, 0, 4, 32'h44);
    vecs[11] = mk(1, 0, 32'h55,       0, 0, 0,           0, 0, 0, 4, 32'h44);
    vecs[12] = mk(1, 10, 32'hA,       1, 11, 32'hB,      0, 0, 1, 10, 32'hA);
    vecs[13] = mk(1, 10, 32'hA,       0, 11, 32'hB,      0, 0, 1, 10, 32'hA);
    vecs[14] = mk(1, 12, 32'hC,       1, 11, 32'hB,      0, 0, 1, 12, 32'hC);
    vecs[15] = mk(1, 12, 32'hC,       1, 11, 32'hB,      0, 0, 1, 12, 32'hC);
    vecs[16] = mk(1, 12, 32'hC,       1, 11, 32'hB,      0, 0, 1, 12, 32'hC);
    vecs[17] = mk(1, 12, 32'hC,       1, 11, 32'hB,      0, 0, 1, 12, 32'hC);
    vecs[18] = mk(1, 12, 32'hC,       1, 11, 32'hB,      1, 1, 1, 11, 32'hB);
    vecs[19] = mk(1, 6, 32'h60,       1, 6, 32'h61,      0, 0, 1, 6, 32'h60);
    vecs[20] = mk(0, 0, 0,            1, 6, 32'h61,      1, 0, 1, 6, 32'h61);

    // Power-on reset.
    #1 reset = 1'b1;
    #1 chk_reset_state("por");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a wait: two denials, then reset with md_req held.
    apply(mk(1, 3, 32'h33, 1, 7, 32'h1234, 0, 0, 1, 3, 32'h33), "pre_rst0");
    apply(mk(1, 3, 32'h33, 1, 7, 32'h1234, 0, 0, 1, 3, 32'h33), "pre_rst1");
    @(negedge clock);
    reset = 1'b1;
    #1 chk_reset_state("mid_rst");
    @(posedge clock);
    #1 reset = 1'b0;
    // Denial history discarded: four more denials before the grant.
    for (int k = 0; k < 5; k++) begin
      if (k == 4)
        apply(mk(1, 3, 32'h33, 1, 7, 32'h1234, 1, 1, 1, 7, 32'h1234), $sformatf("post_rst%0d", k));
      else
        apply(mk(1, 3, 32'h33, 1, 7, 32'h1234, 0, 0, 1, 3, 32'h33), $sformatf("post_rst%0d", k));
    end

    // Continuous contention: one forced stall every five cycles, twenty
    // stalls in total, driving the 4-bit counter into saturation.
    for (int k = 0; k < 100; k++) begin
      if ((k % 5) == 4)
        apply(mk(1, 3, 32'h33, 1, 7, 32'h1234, 1, 1, 1, 7, 32'h1234), $sformatf("sat%0d", k));
      else
        apply(mk(1, 3, 32'h33, 1, 7, 32'h1234, 0, 0, 1, 3, 32'h33), $sformatf("sat%0d", k));
    end
    chk("final stall_cnt4", 32'(bus_s.stall_cnt), 32'd15);
    chk("final stall_cnt",  32'(bus.stall_cnt),   32'd21);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
